// File: rtl/overlap_add_pkg.sv
// Shared framing constants, input-handshake encodings and emitter state type
// for the overlap-add reconstruction block.
package overlap_add_pkg;

    localparam int OLA_FRAME_LEN  = 1024;
    localparam int OLA_HOP        = 160;
    localparam int OLA_NUM_FRAMES = 89;
    localparam int OLA_TOTAL_OUT  = OLA_FRAME_LEN + (OLA_NUM_FRAMES - 1) * OLA_HOP;

    localparam logic [1:0] DI_INVALID = 2'd0;
    localparam logic [1:0] DI_VALID   = 2'd1;
    localparam logic [1:0] DI_WAIT    = 2'd2;

    typedef enum logic [1:0] {
        E_IDLE,
        E_HOP,
        E_TAIL,
        E_DONE
    } emit_state_t;

    // (a + b) mod m for a, b < m: circular addressing into the accumulator.
    function automatic logic [31:0] mod_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] m);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, m})
            mod_add = 32'(s - {1'b0, m});
        else
            mod_add = s[31:0];
    endfunction

endpackage

// File: rtl/overlap_add_acc_ram.sv
// Circular accumulator store: one read-modify-write accumulate port and one
// read-and-clear port; a same-address collision keeps the accumulate.
module ola_acc_ram #(
    parameter int DEPTH = 1024,
    parameter int WIDTH = 17,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    acc_en,
    input  logic [AW-1:0]           acc_addr,
    input  logic signed [WIDTH-1:0] acc_data,
    input  logic                    clr_en,
    input  logic [AW-1:0]           clr_addr,
    output logic signed [WIDTH-1:0] clr_data
);

    logic signed [WIDTH-1:0] mem [DEPTH];

    assign clr_data = mem[clr_addr];

    // Accumulate is written last so it overrides the clear on a collision;
    // the reader still sees the pre-add word through clr_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[AW'(i)] <= '0;
        end else begin
            if (clr_en)
                mem[clr_addr] <= '0;
            if (acc_en)
                mem[acc_addr] <= mem[acc_addr] + acc_data;
        end
    end

endmodule

// File: rtl/overlap_add.sv
// Overlap-add reconstruction: accumulates hopped frames into a circular store
// and streams out each HOP-sized span once no later frame can touch it.
module overlap_add
    import overlap_add_pkg::*;
#(
    parameter int FRAME_LEN  = OLA_FRAME_LEN,
    parameter int HOP        = OLA_HOP,
    parameter int NUM_FRAMES = OLA_NUM_FRAMES,
    parameter int I_BW       = 14,
    parameter int O_BW       = 17,
    localparam int TOTAL_OUT = FRAME_LEN + (NUM_FRAMES - 1) * HOP,
    localparam int AW        = $clog2(FRAME_LEN),
    localparam int OW        = $clog2(TOTAL_OUT),
    localparam int FW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [I_BW-1:0] data_i,
    input  logic [1:0]             di_en,
    input  logic [AW-1:0]          in_num,
    output logic signed [O_BW-1:0] data_o,
    output logic                   do_en,
    output logic [OW-1:0]          out_num,
    output logic                   done,
    output logic                   err
);

    emit_state_t state, state_nx;

    logic [FW-1:0] f;
    logic [AW-1:0] k;
    logic [AW-1:0] base;
    logic [AW-1:0] ebase;
    logic [AW-1:0] ecnt, ecnt_nx;
    logic [OW-1:0] emit_idx;

    logic                   accept;
    logic                   last_k;
    logic                   last_f;
    logic                   frame_done;
    logic                   start;
    logic                   emit;
    logic                   busy_err;
    logic [AW-1:0]          acc_addr;
    logic [AW-1:0]          emit_addr;
    logic signed [O_BW-1:0] acc_data;
    logic signed [O_BW-1:0] clr_data;

    assign accept     = (di_en == DI_VALID) && (state != E_TAIL) && (state != E_DONE);
    assign last_k     = (k == AW'(FRAME_LEN - 1));
    assign last_f     = (f == FW'(NUM_FRAMES - 1));
    assign frame_done = accept && last_k;
    assign acc_addr   = AW'(mod_add(32'(base), 32'(k), 32'(FRAME_LEN)));
    assign acc_data   = {{(O_BW - I_BW){data_i[I_BW-1]}}, data_i};
    assign done       = (state == E_DONE);

    // The first word of a span (at base) is already final when the frame's
    // last sample arrives, so it is emitted on that same edge.
    always_comb begin
        state_nx  = state;
        ecnt_nx   = ecnt;
        emit      = 1'b0;
        start     = 1'b0;
        busy_err  = 1'b0;
        emit_addr = AW'(mod_add(32'(ebase), 32'(ecnt), 32'(FRAME_LEN)));
        case (state)
            E_IDLE: begin
                if (frame_done) begin
                    emit      = 1'b1;
                    start     = 1'b1;
                    emit_addr = base;
                    ecnt_nx   = AW'(1);
                    if (last_f)
                        state_nx = E_TAIL;
                    else if (HOP > 1)
                        state_nx = E_HOP;
                end
            end
            E_HOP: begin
                emit    = 1'b1;
                ecnt_nx = ecnt + 1'b1;
                if (ecnt == AW'(HOP - 1))
                    state_nx = E_IDLE;
                if (frame_done)
                    busy_err = 1'b1;
            end
            E_TAIL: begin
                emit    = 1'b1;
                ecnt_nx = ecnt + 1'b1;
                if (ecnt == AW'(FRAME_LEN - 1))
                    state_nx = E_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= E_IDLE;
            ecnt     <= '0;
            ebase    <= '0;
            f        <= '0;
            k        <= '0;
            base     <= '0;
            emit_idx <= '0;
            data_o   <= '0;
            do_en    <= 1'b0;
            out_num  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nx;
            ecnt  <= ecnt_nx;
            if (start)
                ebase <= base;

            if (accept) begin
                if (last_k) begin
                    k <= '0;
                    if (!last_f) begin
                        f    <= f + 1'b1;
                        base <= AW'(mod_add(32'(base), 32'(HOP), 32'(FRAME_LEN)));
                    end
                end else begin
                    k <= k + 1'b1;
                end
            end

            if ((accept && (in_num != k)) || busy_err)
                err <= 1'b1;

            do_en  <= emit;
            data_o <= emit ? clr_data : '0;
            if (emit) begin
                out_num  <= emit_idx;
                emit_idx <= emit_idx + 1'b1;
            end
        end
    end

    ola_acc_ram #(
        .DEPTH(FRAME_LEN),
        .WIDTH(O_BW)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .acc_en  (accept),
        .acc_addr(acc_addr),
        .acc_data(acc_data),
        .clr_en  (emit),
        .clr_addr(emit_addr),
        .clr_data(clr_data)
    );

endmodule
